// File: rtl/ll_telemetry_tx.sv
// ll_telemetry_tx
//   Serialises one ASCII snapshot of lander state over the board UART
//   transmit handshake. A start strobe in IDLE captures every input. The
//   frame is then sent one byte at a time:
//     "A dddd V sdddd F dddd T dddd st [CR] LF"
//   with a single space between the fields.
//
// Parameters
//   TXCLK_WIDTH : cycles txclk stays high per byte (1..15)
//   EOL_CR      : 1 = frame ends CR LF (28 bytes), 0 = LF only (27 bytes)
//
// Ports
//   clk, rst           : system clock, asynchronous active-high reset
//   start              : frame request, sampled on every rising edge
//   alt, fuel, thrust  : 4-digit BCD values
//   vel                : 4-digit BCD ten's complement, bit 15 = negative
//   land, crash        : status flags (crash wins)
//   txready            : UART can accept a byte
//   txdata, txclk      : byte and strobe; the UART latches on the txclk rise
//   busy               : frame in progress
//   frame_done         : one-cycle pulse after the last byte completes
//   overrun            : sticky, start seen while busy

module ll_telemetry_tx #(
  parameter int TXCLK_WIDTH = 1,
  parameter int EOL_CR      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] alt,
  input  logic [15:0] vel,
  input  logic [15:0] fuel,
  input  logic [15:0] thrust,
  input  logic        land,
  input  logic        crash,
  input  logic        txready,
  output logic [7:0]  txdata,
  output logic        txclk,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    WAIT_LO,
    WAIT_HI,
    DONE
  } state_t;

  localparam logic [4:0] LAST_IDX = (EOL_CR != 0) ? 5'd27 : 5'd26;
  localparam logic [3:0] PULSE_W  = 4'(TXCLK_WIDTH);

  state_t      state, state_n;
  logic [4:0]  idx, idx_n;
  logic [3:0]  pcnt, pcnt_n;
  logic [7:0]  txdata_n;
  logic        txclk_n, busy_n, frame_done_n, overrun_n;
  logic [15:0] alt_q, alt_n, vmag_q, vmag_n, fuel_q, fuel_n, thrust_q, thrust_n;
  logic        vneg_q, vneg_n;
  logic [7:0]  stat_q, stat_n;
  logic [7:0]  cur_byte;

  // BCD ten's complement (0000 - v), one digit at a time with borrow.
  // For a negative velocity this yields its magnitude.
  function automatic logic [15:0] bcd_negate(input logic [15:0] v);
    logic [15:0] r;
    logic        b;
    logic [4:0]  d;
    r = '0;
    b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = 5'd0 - {1'b0, v[i*4 +: 4]} - {4'd0, b};
      if (d[4]) begin
        d = d + 5'd10;
        b = 1'b1;
      end else begin
        b = 1'b0;
      end
      r[i*4 +: 4] = d[3:0];
    end
    return r;
  endfunction

  // Non-decimal nibbles are shown as '?' so the frame stays printable.
  function automatic logic [7:0] digit_char(input logic [3:0] nib);
    if (nib <= 4'd9) return 8'h30 | {4'h0, nib};
    else             return 8'h3F;
  endfunction

  // Byte at position idx of the frame, built from the snapshot registers.
  always_comb begin
    cur_byte = 8'h0A;
    case (idx)
      5'd0:    cur_byte = 8'h41;
      5'd1:    cur_byte = digit_char(alt_q[15:12]);
      5'd2:    cur_byte = digit_char(alt_q[11:8]);
      5'd3:    cur_byte = digit_char(alt_q[7:4]);
      5'd4:    cur_byte = digit_char(alt_q[3:0]);
      5'd5:    cur_byte = 8'h20;
      5'd6:    cur_byte = 8'h56;
      5'd7:    cur_byte = vneg_q ? 8'h2D : 8'h2B;
      5'd8:    cur_byte = digit_char(vmag_q[15:12]);
      5'd9:    cur_byte = digit_char(vmag_q[11:8]);
      5'd10:   cur_byte = digit_char(vmag_q[7:4]);
      5'd11:   cur_byte = digit_char(vmag_q[3:0]);
      5'd12:   cur_byte = 8'h20;
      5'd13:   cur_byte = 8'h46;
      5'd14:   cur_byte = digit_char(fuel_q[15:12]);
      5'd15:   cur_byte = digit_char(fuel_q[11:8]);
      5'd16:   cur_byte = digit_char(fuel_q[7:4]);
      5'd17:   cur_byte = digit_char(fuel_q[3:0]);
      5'd18:   cur_byte = 8'h20;
      5'd19:   cur_byte = 8'h54;
      5'd20:   cur_byte = digit_char(thrust_q[15:12]);
      5'd21:   cur_byte = digit_char(thrust_q[11:8]);
      5'd22:   cur_byte = digit_char(thrust_q[7:4]);
      5'd23:   cur_byte = digit_char(thrust_q[3:0]);
      5'd24:   cur_byte = 8'h20;
      5'd25:   cur_byte = stat_q;
      5'd26:   cur_byte = (EOL_CR != 0) ? 8'h0D : 8'h0A;
      default: cur_byte = 8'h0A;
    endcase
  end

  // Next-state and next-output logic. Every output is registered from
  // these values, so nothing reaches an output port combinationally.
  always_comb begin
    state_n      = state;
    idx_n        = idx;
    pcnt_n       = pcnt;
    txdata_n     = txdata;
    txclk_n      = txclk;
    frame_done_n = 1'b0;
    overrun_n    = overrun | (start && (state != IDLE));
    alt_n        = alt_q;
    vmag_n       = vmag_q;
    vneg_n       = vneg_q;
    fuel_n       = fuel_q;
    thrust_n     = thrust_q;
    stat_n       = stat_q;

    case (state)
      IDLE: begin
        if (start) begin
          alt_n    = alt;
          vneg_n   = vel[15];
          vmag_n   = vel[15] ? bcd_negate(vel) : vel;
          fuel_n   = fuel;
          thrust_n = thrust;
          stat_n   = crash ? 8'h43 : (land ? 8'h4C : 8'h46);
          idx_n    = 5'd0;
          state_n  = SETUP;
        end
      end
      SETUP: begin
        txdata_n = cur_byte;
        pcnt_n   = 4'd0;
        if (txready) state_n = PULSE;
      end
      PULSE: begin
        // The rise is held back if txready dropped after SETUP, so txclk
        // never rises while the UART is not ready.
        if (pcnt == PULSE_W) begin
          txclk_n = 1'b0;
          state_n = WAIT_LO;
        end else if ((pcnt != 4'd0) || txready) begin
          txclk_n = 1'b1;
          pcnt_n  = pcnt + 4'd1;
        end
      end
      WAIT_LO: begin
        if (!txready) state_n = WAIT_HI;
      end
      WAIT_HI: begin
        if (txready) begin
          if (idx == LAST_IDX) begin
            state_n      = DONE;
            frame_done_n = 1'b1;
          end else begin
            idx_n   = idx + 5'd1;
            state_n = SETUP;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  // State, output and snapshot registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= 5'd0;
      pcnt       <= 4'd0;
      txdata     <= 8'd0;
      txclk      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      alt_q      <= 16'd0;
      vmag_q     <= 16'd0;
      vneg_q     <= 1'b0;
      fuel_q     <= 16'd0;
      thrust_q   <= 16'd0;
      stat_q     <= 8'd0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      pcnt       <= pcnt_n;
      txdata     <= txdata_n;
      txclk      <= txclk_n;
      busy       <= busy_n;
      frame_done <= frame_done_n;
      overrun    <= overrun_n;
      alt_q      <= alt_n;
      vmag_q     <= vmag_n;
      vneg_q     <= vneg_n;
      fuel_q     <= fuel_n;
      thrust_q   <= thrust_n;
      stat_q     <= stat_n;
    end
  end

endmodule

// File: tb/tb_ll_telemetry_tx.sv
// Bench for ll_telemetry_tx. Two instances are built: dut_a with default
// parameters (CR LF, 1-cycle strobe) and dut_b with EOL_CR=0 and
// TXCLK_WIDTH=3. 'sel' chooses which instance the UART model and the
// frame checker follow; the other one sits idle.

module tb_ll_telemetry_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sel = 1'b0;
  logic [15:0] alt = 16'd0, vel = 16'd0, fuel = 16'd0, thrust = 16'd0;
  logic        land = 1'b0, crash = 1'b0;

  logic        rdy = 1'b1;
  logic        force_low = 1'b0;
  int          ack_cnt = 0;

  logic        start_a, start_b, txready_a, txready_b;
  logic [7:0]  txdata_a, txdata_b;
  logic        txclk_a, txclk_b, busy_a, busy_b;
  logic        frame_done_a, frame_done_b, overrun_a, overrun_b;

  logic [7:0]  m_txdata;
  logic        m_txclk, m_busy, m_frame_done, m_overrun, m_txready;

  int          total = 0;
  int          bad = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  rx_buf[$];

  assign start_a   = start & ~sel;
  assign start_b   = start & sel;
  assign txready_a = sel ? 1'b1 : rdy;
  assign txready_b = sel ? rdy : 1'b1;

  assign m_txdata     = sel ? txdata_b     : txdata_a;
  assign m_txclk      = sel ? txclk_b      : txclk_a;
  assign m_busy       = sel ? busy_b       : busy_a;
  assign m_frame_done = sel ? frame_done_b : frame_done_a;
  assign m_overrun    = sel ? overrun_b    : overrun_a;
  assign m_txready    = sel ? txready_b    : txready_a;

  ll_telemetry_tx dut_a (
    .clk(clk), .rst(rst), .start(start_a),
    .alt(alt), .vel(vel), .fuel(fuel), .thrust(thrust),
    .land(land), .crash(crash), .txready(txready_a),
    .txdata(txdata_a), .txclk(txclk_a), .busy(busy_a),
    .frame_done(frame_done_a), .overrun(overrun_a)
  );

  ll_telemetry_tx #(.TXCLK_WIDTH(3), .EOL_CR(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .alt(alt), .vel(vel), .fuel(fuel), .thrust(thrust),
    .land(land), .crash(crash), .txready(txready_b),
    .txdata(txdata_b), .txclk(txclk_b), .busy(busy_b),
    .frame_done(frame_done_b), .overrun(overrun_b)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, required, $time);
    end
  endtask

  // Behavioural frame model: spell the frame out from the field values.
  task automatic pushBcd(input logic [15:0] x);
    logic [3:0] nib;
    for (int i = 3; i >= 0; i--) begin
      nib = x[i*4 +: 4];
      exp_q.push_back((nib <= 4'd9) ? (8'h30 + {4'h0, nib}) : 8'h3F);
    end
  endtask

  task automatic pushFrame(input logic cr);
    int v, mag;
    exp_q.push_back(8'h41);
    pushBcd(alt);
    exp_q.push_back(8'h20);
    exp_q.push_back(8'h56);
    v = 1000 * int'(vel[15:12]) + 100 * int'(vel[11:8]) + 10 * int'(vel[7:4]) + int'(vel[3:0]);
    if (vel[15]) begin
      mag = 10000 - v;
      exp_q.push_back(8'h2D);
    end else begin
      mag = v;
      exp_q.push_back(8'h2B);
    end
    exp_q.push_back(8'h30 + 8'((mag / 1000) % 10));
    exp_q.push_back(8'h30 + 8'((mag / 100) % 10));
    exp_q.push_back(8'h30 + 8'((mag / 10) % 10));
    exp_q.push_back(8'h30 + 8'(mag % 10));
    exp_q.push_back(8'h20);
    exp_q.push_back(8'h46);
    pushBcd(fuel);
    exp_q.push_back(8'h20);
    exp_q.push_back(8'h54);
    pushBcd(thrust);
    exp_q.push_back(8'h20);
    exp_q.push_back(crash ? 8'h43 : (land ? 8'h4C : 8'h46));
    if (cr) exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // UART model: drops txready once it sees the strobe, raises it 4 cycles later.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      rdy = 1'b1;
      ack_cnt = 0;
    end else if (force_low) begin
      rdy = 1'b0;
      ack_cnt = 0;
    end else if (ack_cnt > 0) begin
      ack_cnt--;
      if (ack_cnt == 0) rdy = 1'b1;
    end else if (m_txclk && rdy) begin
      rdy = 1'b0;
      ack_cnt = 4;
    end else begin
      rdy = 1'b1;
    end
  end

  // Per-cycle checker of the selected instance against the model queue.
  logic       prev_clk = 1'b0, prev_ready = 1'b1, prev_fd = 1'b0;
  logic [7:0] prev_data = 8'd0, held_data = 8'd0, exp_b;
  int         hi_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_clk = 1'b0;
      prev_fd = 1'b0;
      prev_ready = 1'b1;
      hi_cnt = 0;
    end else begin
      if (m_txclk && !prev_clk) begin
        checkOutput("ready_at_rise", 32'(prev_ready), 32'd1);
        checkOutput("data_setup", 32'(m_txdata), 32'(prev_data));
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("[TB] FAIL unexpected_byte actual=%0h required=none at %0t", m_txdata, $time);
        end else begin
          exp_b = exp_q.pop_front();
          if (m_txdata !== exp_b) begin
            bad++;
            $display("[TB] FAIL frame_byte actual=%0h required=%0h at %0t", m_txdata, exp_b, $time);
          end
        end
        rx_buf.push_back(m_txdata);
        held_data = m_txdata;
        hi_cnt = 1;
      end else if (m_txclk) begin
        hi_cnt++;
        checkOutput("data_hold", 32'(m_txdata), 32'(held_data));
      end else if (prev_clk) begin
        checkOutput("pulse_width", 32'(hi_cnt), sel ? 32'd3 : 32'd1);
      end
      if (m_frame_done) begin
        checkOutput("done_queue_empty", 32'(exp_q.size()), 32'd0);
        checkOutput("done_one_cycle", 32'(prev_fd), 32'd0);
      end
      prev_clk = m_txclk;
      prev_ready = m_txready;
      prev_data = m_txdata;
      prev_fd = m_frame_done;
    end
  end

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] v,
                               input logic [15:0] f, input logic [15:0] t,
                               input logic l, input logic c);
    @(negedge clk);
    alt = a; vel = v; fuel = f; thrust = t; land = l; crash = c;
    rx_buf.delete();
    pushFrame(!sel);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    checkOutput("busy_rise", 32'(m_busy), 32'd1);
  endtask

  task automatic waitFrame(input string name, input int budget);
    int n = 0;
    while (m_frame_done !== 1'b1 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput({name, "_done_seen"}, 32'(m_frame_done), 32'd1);
    @(negedge clk);
    #1;
    checkOutput({name, "_done_pulse"}, 32'(m_frame_done), 32'd0);
    checkOutput({name, "_busy_low"}, 32'(m_busy), 32'd0);
  endtask

  task automatic checkField(input string name, input int first, input string s);
    for (int i = 0; i < s.len(); i++) begin
      if (first + i < rx_buf.size())
        checkOutput(name, 32'(rx_buf[first + i]), 32'(s[i]));
      else
        checkOutput(name, 32'hDEAD, 32'(s[i]));
    end
  endtask

  initial begin
    string lit;
    int    n;
    int    cr_seen;

    // Reset state of both instances.
    repeat (2) @(negedge clk);
    checkOutput("rst_txdata", 32'(txdata_a), 32'd0);
    checkOutput("rst_txclk", 32'(txclk_a), 32'd0);
    checkOutput("rst_busy", 32'(busy_a), 32'd0);
    checkOutput("rst_frame_done", 32'(frame_done_a), 32'd0);
    checkOutput("rst_overrun", 32'(overrun_a), 32'd0);
    checkOutput("rst_busy_b", 32'(busy_b), 32'd0);
    rst = 1'b0;

    // Frame 1: plain values, literal pin of the whole frame.
    applyStimulus(16'h4500, 16'h0000, 16'h0800, 16'h0005, 1'b0, 1'b0);
    waitFrame("f1", 2000);
    checkOutput("f1_len", 32'(rx_buf.size()), 32'd28);
    lit = "A4500 V+0000 F0800 T0005 F";
    checkField("f1_text", 0, lit);
    if (rx_buf.size() == 28) begin
      checkOutput("f1_cr", 32'(rx_buf[26]), 32'h0D);
      checkOutput("f1_lf", 32'(rx_buf[27]), 32'h0A);
    end

    // Frame 2: negative velocity, crash beats land.
    applyStimulus(16'h1000, 16'h9970, 16'h0500, 16'h0010, 1'b1, 1'b1);
    waitFrame("f2", 2000);
    checkField("f2_vel", 7, "-0030");
    checkField("f2_stat", 25, "C");

    // Frame 3: zero velocity, landed.
    applyStimulus(16'h0250, 16'h0000, 16'h0300, 16'h0001, 1'b1, 1'b0);
    waitFrame("f3", 2000);
    checkField("f3_vel", 7, "+0000");
    checkField("f3_stat", 25, "L");

    // Stall: txready low for 50 cycles, first byte waits without a strobe.
    force_low = 1'b1;
    repeat (2) @(negedge clk);
    applyStimulus(16'h0100, 16'h9995, 16'h9999, 16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      checkOutput("stall_txclk", 32'(m_txclk), 32'd0);
      checkOutput("stall_txdata", 32'(m_txdata), 32'h41);
    end
    force_low = 1'b0;
    waitFrame("f4", 2000);
    checkOutput("f4_len", 32'(rx_buf.size()), 32'd28);
    checkField("f4_vel", 7, "-0005");

    // Overrun: second start at byte 10, alt changed mid-frame.
    checkOutput("ovr_clear_before", 32'(m_overrun), 32'd0);
    applyStimulus(16'h2468, 16'h0150, 16'h0700, 16'h0020, 1'b0, 1'b0);
    n = 0;
    while (rx_buf.size() < 10 && n < 600) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("ovr_reach_byte10", 32'(rx_buf.size()), 32'd10);
    @(negedge clk);
    start = 1'b1;
    alt = 16'h1357;
    @(negedge clk);
    start = 1'b0;
    #1;
    checkOutput("ovr_set", 32'(m_overrun), 32'd1);
    waitFrame("f5", 2000);
    checkOutput("f5_len", 32'(rx_buf.size()), 32'd28);
    checkField("f5_alt", 1, "2468");
    repeat (30) @(negedge clk);
    #1;
    checkOutput("ovr_sticky", 32'(m_overrun), 32'd1);
    checkOutput("ovr_no_second_busy", 32'(m_busy), 32'd0);
    checkOutput("ovr_no_extra_bytes", 32'(rx_buf.size()), 32'd28);

    // Reset during the strobe of byte 5, then a clean full frame.
    applyStimulus(16'h3333, 16'h0042, 16'h0111, 16'h0222, 1'b0, 1'b0);
    n = 0;
    while (!(rx_buf.size() == 6 && m_txclk) && n < 600) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("rst_reach_byte5", 32'(rx_buf.size()), 32'd6);
    checkOutput("rst_in_pulse", 32'(m_txclk), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_txclk", 32'(m_txclk), 32'd0);
    checkOutput("rst_mid_busy", 32'(m_busy), 32'd0);
    checkOutput("rst_mid_overrun", 32'(m_overrun), 32'd0);
    exp_q.delete();
    rx_buf.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    applyStimulus(16'h3333, 16'h0042, 16'h0111, 16'h0222, 1'b0, 1'b0);
    waitFrame("f6", 2000);
    checkOutput("f6_len", 32'(rx_buf.size()), 32'd28);
    checkField("f6_first", 0, "A3333");

    // Second instance: LF only, 3-cycle strobe, non-decimal altitude digit.
    @(negedge clk);
    sel = 1'b1;
    applyStimulus(16'h4A00, 16'h0042, 16'h1234, 16'h0099, 1'b1, 1'b0);
    waitFrame("f7", 2000);
    checkOutput("f7_len", 32'(rx_buf.size()), 32'd27);
    checkField("f7_alt", 1, "4?00");
    cr_seen = 0;
    foreach (rx_buf[i]) if (rx_buf[i] == 8'h0D) cr_seen++;
    checkOutput("f7_no_cr", 32'(cr_seen), 32'd0);
    if (rx_buf.size() == 27) checkOutput("f7_lf", 32'(rx_buf[26]), 32'h0A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
